// File: rtl/definitions_pkg.sv
// Shared types for the parameterised up/down counter and its prescaler.
package definitions_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP,
        CNT_SAT,
        CNT_ONESHOT
    } cnt_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cnt_state_e;

endpackage

// File: rtl/cnt_param_if.sv
// Signal bundle for driving counter_ud_param from a bench or parent block.
interface cnt_param_if #(
    parameter int WIDTH = 4
) (
    input logic clk
);
    logic             rst;
    logic             en;
    logic             down;
    logic             load_en;
    logic [WIDTH-1:0] load;
    logic [WIDTH-1:0] count;
    logic             rollover;
    logic             tc;
    logic             sat;
    logic             done;

    modport dut (input clk, rst, en, down, load_en, load,
                 output count, rollover, tc, sat, done);
endinterface

// File: rtl/cnt_prescaler.sv
// Divides enabled cycles: step pulses on every PRESCALE-th cycle with en=1.
module cnt_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);
    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign step = en && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/counter_ud_param.sv
// Up/down counter with prescaled stepping, load, and wrap/saturate/one-shot
// boundary behaviour selected by MODE.
module counter_ud_param
    import definitions_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter cnt_mode_e        MODE     = CNT_WRAP,
    parameter int               PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             down,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] count,
    output logic             rollover,
    output logic             tc,
    output logic             sat,
    output logic             done
);
    cnt_state_e       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             roll_q, roll_d;
    logic             sat_q, sat_d;
    logic             done_q, done_d;
    logic             step;
    logic             at_bound;

    // Gating en in DONE keeps the prescaler frozen along with the count.
    cnt_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .en   (en && (state_q != DONE)),
        .clr  (load_en),
        .step (step)
    );

    assign at_bound = down ? (count_q == '0) : (count_q == MAX_VAL);

    always_comb begin
        count_d = count_q;
        roll_d  = 1'b0;
        sat_d   = sat_q;
        state_d = state_q;

        case (state_q)
            IDLE:    if (en)  state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = state_q;
        endcase

        if (load_en) begin
            count_d = (load > MAX_VAL) ? MAX_VAL : load;
            sat_d   = 1'b0;
            state_d = IDLE;
        end else if (step) begin
            if (!at_bound) begin
                count_d = down ? count_q - 1'b1 : count_q + 1'b1;
                sat_d   = 1'b0;
            end else begin
                case (MODE)
                    CNT_WRAP: begin
                        count_d = down ? MAX_VAL : '0;
                        roll_d  = 1'b1;
                    end
                    CNT_SAT:  sat_d   = 1'b1;
                    default:  state_d = DONE;
                endcase
            end
        end

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            roll_q  <= 1'b0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            roll_q  <= roll_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
        end
    end

    assign count    = count_q;
    assign rollover = roll_q;
    assign tc       = at_bound;
    assign sat      = sat_q;
    assign done     = done_q;
endmodule

// File: tb/tb_counter_ud_param.sv
// Random + directed bench: three counter configurations against an
// arithmetic reference model.
module tb_counter_ud_param;
    import definitions_pkg::*;

    localparam int W  = 4;
    localparam int MV = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    bit         cur_rst, cur_en, cur_down, cur_ld;
    logic [3:0] cur_lv;

    int n_chk = 0;
    int n_err = 0;

    // model state, index 0 = wrap/p1, 1 = sat/p1, 2 = oneshot/p3
    cnt_mode_e cfg_mode [3] = '{CNT_WRAP, CNT_SAT, CNT_ONESHOT};
    int        cfg_pre  [3] = '{1, 1, 3};
    int        m_cnt [3];
    int        m_pre [3];
    bit        m_sat [3];
    bit        m_done[3];
    bit        m_roll[3];

    cnt_param_if #(.WIDTH(W)) if_w (.clk(clk));
    cnt_param_if #(.WIDTH(W)) if_s (.clk(clk));
    cnt_param_if #(.WIDTH(W)) if_o (.clk(clk));

    assign if_w.rst = cur_rst;  assign if_s.rst = cur_rst;  assign if_o.rst = cur_rst;
    assign if_w.en = cur_en;    assign if_s.en = cur_en;    assign if_o.en = cur_en;
    assign if_w.down = cur_down; assign if_s.down = cur_down; assign if_o.down = cur_down;
    assign if_w.load_en = cur_ld; assign if_s.load_en = cur_ld; assign if_o.load_en = cur_ld;
    assign if_w.load = cur_lv;  assign if_s.load = cur_lv;  assign if_o.load = cur_lv;

    counter_ud_param #(.WIDTH(W), .MAX_VAL(4'd9), .MODE(CNT_WRAP), .PRESCALE(1)) u_wrap (
        .clk(if_w.clk), .rst(if_w.rst), .en(if_w.en), .down(if_w.down),
        .load_en(if_w.load_en), .load(if_w.load), .count(if_w.count),
        .rollover(if_w.rollover), .tc(if_w.tc), .sat(if_w.sat), .done(if_w.done));

    counter_ud_param #(.WIDTH(W), .MAX_VAL(4'd9), .MODE(CNT_SAT), .PRESCALE(1)) u_sat (
        .clk(if_s.clk), .rst(if_s.rst), .en(if_s.en), .down(if_s.down),
        .load_en(if_s.load_en), .load(if_s.load), .count(if_s.count),
        .rollover(if_s.rollover), .tc(if_s.tc), .sat(if_s.sat), .done(if_s.done));

    counter_ud_param #(.WIDTH(W), .MAX_VAL(4'd9), .MODE(CNT_ONESHOT), .PRESCALE(3)) u_os (
        .clk(if_o.clk), .rst(if_o.rst), .en(if_o.en), .down(if_o.down),
        .load_en(if_o.load_en), .load(if_o.load), .count(if_o.count),
        .rollover(if_o.rollover), .tc(if_o.tc), .sat(if_o.sat), .done(if_o.done));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_sat[i] = 0; m_done[i] = 0; m_roll[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        bit bnd;
        m_roll[i] = 0;
        if (cur_ld) begin
            m_cnt[i]  = (int'(cur_lv) > MV) ? MV : int'(cur_lv);
            m_pre[i]  = 0;
            m_sat[i]  = 0;
            m_done[i] = 0;
        end else if (cur_en && !m_done[i]) begin
            m_pre[i]++;
            if (m_pre[i] == cfg_pre[i]) begin
                m_pre[i] = 0;
                bnd = cur_down ? (m_cnt[i] == 0) : (m_cnt[i] == MV);
                if (!bnd) begin
                    m_cnt[i] = cur_down ? m_cnt[i] - 1 : m_cnt[i] + 1;
                    m_sat[i] = 0;
                end else if (cfg_mode[i] == CNT_WRAP) begin
                    m_cnt[i]  = cur_down ? MV : 0;
                    m_roll[i] = 1;
                end else if (cfg_mode[i] == CNT_SAT) begin
                    m_sat[i] = 1;
                end else begin
                    m_done[i] = 1;
                end
            end
        end
    endtask

    task automatic chk_dut(input string tag, input int i, input logic [3:0] c,
                           input logic r, input logic t, input logic s, input logic d);
        chk({tag, ".count"}, 32'(c), 32'(m_cnt[i]));
        chk({tag, ".rollover"}, 32'(r), 32'(m_roll[i]));
        chk({tag, ".tc"}, 32'(t), 32'(cur_down ? (m_cnt[i] == 0) : (m_cnt[i] == MV)));
        chk({tag, ".sat"}, 32'(s), 32'(m_sat[i]));
        chk({tag, ".done"}, 32'(d), 32'(m_done[i]));
    endtask

    task automatic check_all(input string tag);
        chk_dut({tag, ".wrap"}, 0, if_w.count, if_w.rollover, if_w.tc, if_w.sat, if_w.done);
        chk_dut({tag, ".sat"},  1, if_s.count, if_s.rollover, if_s.tc, if_s.sat, if_s.done);
        chk_dut({tag, ".os"},   2, if_o.count, if_o.rollover, if_o.tc, if_o.sat, if_o.done);
    endtask

    task automatic cyc(input bit e, input bit dn, input bit ld, input logic [3:0] lv);
        @(negedge clk);
        cur_en = e; cur_down = dn; cur_ld = ld; cur_lv = lv;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        check_all("cyc");
    endtask

    task automatic do_rst();
        @(negedge clk);
        cur_rst = 1; cur_en = 0; cur_ld = 0; cur_down = 0;
        #1;
        model_reset();
        check_all("rst");
        @(negedge clk);
        cur_rst = 0;
    endtask

    // Pulse reset between edges; outputs must clear without a clock edge.
    task automatic async_pulse();
        #1 cur_rst = 1;
        #1;
        model_reset();
        check_all("arst");
        #1 cur_rst = 0;
    endtask

    initial begin
        cur_rst = 1; cur_en = 0; cur_down = 0; cur_ld = 0; cur_lv = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all("reset");
        cur_rst = 0;

        // count up 0..9 then wrap
        repeat (11) cyc(1, 0, 0, 4'd0);
        chk("wrap_after_11", 32'(if_w.count), 32'd1);

        // down from 0
        do_rst();
        cur_down = 1;
        #1 chk("tc_at0", 32'(if_w.tc), 32'd1);
        cyc(1, 1, 0, 4'd0);
        chk("down_wrap_cnt", 32'(if_w.count), 32'd9);
        chk("down_wrap_roll", 32'(if_w.rollover), 32'd1);

        // saturate with clamped load
        cyc(0, 0, 1, 4'd15);
        chk("clamp", 32'(if_s.count), 32'd9);
        cyc(1, 0, 0, 4'd0);
        chk("sat_hold", 32'(if_s.sat), 32'd1);
        cyc(1, 1, 0, 4'd0);
        chk("sat_leave", 32'(if_s.count), 32'd8);
        chk("sat_clr", 32'(if_s.sat), 32'd0);

        // one-shot with prescale 3
        do_rst();
        repeat (36) cyc(1, 0, 0, 4'd0);
        chk("os_done", 32'(if_o.done), 32'd1);
        chk("os_cnt9", 32'(if_o.count), 32'd9);
        cyc(0, 0, 1, 4'd2);
        chk("os_load", 32'(if_o.count), 32'd2);
        chk("os_state", 32'(u_os.state_q), 32'(IDLE));

        // asynchronous reset mid-count and mid-prescale
        do_rst();
        repeat (5) cyc(1, 0, 0, 4'd0);
        chk("pre_arst", 32'(if_w.count), 32'd5);
        async_pulse();
        repeat (8) cyc(1, 0, 0, 4'd0);

        // load beats a coincident wrap step
        cyc(0, 0, 1, 4'd9);
        cyc(1, 0, 1, 4'd4);
        chk("ld_win_cnt", 32'(if_w.count), 32'd4);
        chk("ld_win_roll", 32'(if_w.rollover), 32'd0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 15) == 0, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 49) == 0) async_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/counter_ud_param.md
COUNTER_UD_PARAM -- requirements
Module: counter_ud_param

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits (2..32).
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1: terminal value, so the modulus is MAX_VAL+1; legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter MODE, default CNT_WRAP: boundary behaviour, one of CNT_WRAP, CNT_SAT or CNT_ONESHOT.
REQ-004 SHALL have parameter PRESCALE, default 1: number of enabled cycles per count step (1..256).
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port en, input, 1: count enable, feeds the prescaler.
REQ-008 SHALL have port down, input, 1: 1 = count down, 0 = count up.
REQ-009 SHALL have port load_en, input, 1: synchronous load strobe.
REQ-010 SHALL have port load, input, WIDTH: load value.
REQ-011 SHALL have port count, output, WIDTH: registered counter value.
REQ-012 SHALL have port rollover, output, 1: registered one-cycle pulse on wrap.
REQ-013 SHALL have port tc, output, 1: combinational terminal-count flag.
REQ-014 SHALL have port sat, output, 1: registered flag, high while held at a boundary (CNT_SAT).
REQ-015 SHALL have port done, output, 1: registered flag, high while in state DONE.

Function
REQ-016 SHALL apply priority rst > load_en > count step.
REQ-017 SHALL load a value into count in the cycle after load_en, clamping any value above MAX_VAL to MAX_VAL.
REQ-018 SHALL, on load_en, clear the prescaler, clear sat, and move the FSM to IDLE.
REQ-019 SHALL have a prescaler that asserts step once every PRESCALE cycles in which en=1, with PRESCALE=1 meaning step on every cycle with en=1.
REQ-020 SHALL hold the prescaler count while en=0 and never reset it on a change of down.
REQ-021 SHALL, on step with down=0, set count to count+1 when count<MAX_VAL.
REQ-022 SHALL, on step with down=1, set count to count-1 when count>0.
REQ-023 SHALL, on an up step at MAX_VAL, behave per MODE: CNT_WRAP -> count=0 with rollover=1 for one cycle; CNT_SAT -> hold with sat=1; CNT_ONESHOT -> hold and enter DONE.
REQ-024 SHALL, on a down step at 0, behave per MODE: CNT_WRAP -> count=MAX_VAL with rollover=1; CNT_SAT -> hold with sat=1; CNT_ONESHOT -> hold and enter DONE.
REQ-025 SHALL clear sat on the first step that moves count away from the boundary.
REQ-026 SHALL assert tc=1 when (down=0 and count==MAX_VAL) or (down=1 and count==0).
REQ-027 SHALL implement FSM states IDLE, RUN and DONE.
REQ-028 SHALL make FSM transitions: IDLE->RUN when en=1; RUN->IDLE when en=0; RUN->DONE on a boundary step (CNT_ONESHOT only); DONE->IDLE only on load_en.
REQ-029 SHALL ignore en in DONE, with count frozen.
REQ-030 SHALL let load_en win over a coincident boundary step, so that neither rollover nor DONE occurs.

Reset
REQ-031 SHALL, while rst=1, immediately force count=0, rollover=0, sat=0, done=0, prescaler=0 and FSM=IDLE, regardless of clk.
REQ-032 SHALL, when rst is asserted mid-count or mid-prescale, discard all progress, with the first step occurring PRESCALE enabled cycles after rst deasserts.

Structure
REQ-033 SHALL have enums cnt_mode_e (CNT_WRAP, CNT_SAT, CNT_ONESHOT) and cnt_state_e (IDLE, RUN, DONE) in definitions_pkg.
REQ-034 SHALL implement the prescaler as sub-module cnt_prescaler (parameter PRESCALE; ports clk, rst, en, clr, step).
REQ-035 SHALL have a bench that drives the block through a parametrised interface cnt_param_if #(WIDTH), instantiated with clk.

Verification
REQ-036 SHALL check, with WIDTH=4, MAX_VAL=9, CNT_WRAP, PRESCALE=1, up and en=1 from 0: count 0..9 then 0, with rollover high only in the cycle count becomes 0.
REQ-037 SHALL check, with the same configuration and down=1 from 0: count becomes 9 with rollover=1, and tc=1 at count=0.
REQ-038 SHALL check, with CNT_SAT, load=15 and load_en: count=9 (clamped); an up step holds at 9 with sat=1; down=1 then gives 8 with sat=0.
REQ-039 SHALL check, with CNT_ONESHOT, PRESCALE=3, en=1 from 0: count steps every 3 cycles; done=1 at 9 and stays there with en held; load_en with load=2 gives count=2 and FSM=IDLE.
REQ-040 SHALL check, with rst pulsed asynchronously at count=5 between edges: all outputs go to 0 immediately; after release, the first step occurs PRESCALE enabled cycles later.
REQ-041 SHALL check load_en with load=4, coincident with an up step at MAX_VAL in CNT_WRAP: count=4 and rollover=0.
